// File: rtl/spi_master_fifo_pkg.sv
// Shared definitions for the FIFO-buffered SPI master: register map, bit positions,
// FSM states and the default SCLK divider width.
package spi_master_fifo_pkg;

  localparam int W_DIV_DEFAULT = 8;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_BUSY     = 4;
  localparam int ST_TX_OVF   = 5;
  localparam int ST_RX_OVF   = 6;
  localparam int ST_RX_UDF   = 7;

  localparam int CT_EN      = 0;
  localparam int CT_CPOL    = 1;
  localparam int CT_CPHA    = 2;
  localparam int CT_IE_TX   = 3;
  localparam int CT_IE_RX   = 4;
  localparam int CT_DIV_LSB = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE
  } spi_state_e;

endpackage

// File: rtl/spi_master_fifo_fifo.sv
// Synchronous FIFO used for both SPI directions. Pointers carry one extra wrap bit so
// full and empty fall out of a single compare; the head entry is visible without a pop.
module spi_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]  wptr_q, rptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/spi_master_fifo.sv
// CPU-facing SPI master with TX/RX FIFOs, programmable CPOL/CPHA and SCLK divider,
// and sticky overflow/underflow flags, accessed through DATA/STATUS/CTRL registers.
module spi_master_fifo
  import spi_master_fifo_pkg::*;
#(
  parameter int W_DATA     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int W_DIV      = W_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        addr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [W_DATA-1:0] wdata,
  output logic [W_DATA-1:0] rdata,
  output logic              irq,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  localparam int W_BCNT = $clog2(W_DATA) + 1;

  spi_state_e        state_q, state_d;
  logic [W_DIV-1:0]  cnt_q, cnt_d, div_q;
  logic [W_BCNT-1:0] bit_cnt_q, bit_cnt_d;
  logic [W_DATA-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rdata_q;
  logic              sclk_q, sclk_d, mosi_q, mosi_d, lead_q, lead_d, cs_n_q;
  logic              en_q, cpol_q, cpha_q, ie_tx_q, ie_rx_q;
  logic              tx_ovf_q, rx_ovf_q, rx_udf_q, pushed_q;
  logic [1:0]        miso_sync_q, samp_pipe_q;
  logic              half_done, sample_fire, tx_pop, rx_push, rx_pop, busy;
  logic              wr_data, rd_data, wr_status, wr_ctrl;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [W_DATA-1:0] tx_head, rx_head, status_word, ctrl_word;

  assign wr_data   = wr_en && (addr == A_DATA);
  assign rd_data   = rd_en && (addr == A_DATA);
  assign wr_status = wr_en && (addr == A_STATUS);
  assign wr_ctrl   = wr_en && (addr == A_CTRL);
  assign rx_pop    = rd_data && !rx_empty;
  assign busy      = (state_q != S_IDLE);
  assign half_done = (cnt_q == div_q);

  spi_fifo #(.W(W_DATA), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_data),
    .pop_i   (tx_pop),
    .wdata_i (wdata),
    .head_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  spi_fifo #(.W(W_DATA), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .wdata_i (rx_sh_q),
    .head_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + W_DIV'(1);
    bit_cnt_d   = bit_cnt_q;
    tx_sh_d     = tx_sh_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    lead_d      = lead_q;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;
    sample_fire = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        sclk_d = cpol_q;
        if (en_q && !tx_empty) state_d = S_SETUP;
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          tx_pop    = 1'b1;
          tx_sh_d   = tx_head;
          bit_cnt_d = W_BCNT'(W_DATA);
          lead_d    = 1'b1;
          if (!cpha_q) mosi_d = tx_head[W_DATA-1];
        end
        if (half_done) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (half_done) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          lead_d = ~lead_q;
          if (lead_q) begin
            if (cpha_q) mosi_d = tx_sh_q[W_DATA-1];
            else        sample_fire = 1'b1;
          end else begin
            tx_sh_d   = tx_sh_q << 1;
            bit_cnt_d = bit_cnt_q - W_BCNT'(1);
            if (cpha_q) sample_fire = 1'b1;
            else        mosi_d = tx_sh_q[W_DATA-2];
            if (bit_cnt_q == W_BCNT'(1)) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + W_DIV'(1);
        // The last miso bit is still in the synchroniser pipe for a couple of clocks.
        if (!pushed_q && (samp_pipe_q == '0)) begin
          rx_push = 1'b1;
          if (en_q && !tx_empty) begin
            cnt_d   = '0;
            state_d = S_SETUP;
          end
        end else if (pushed_q && (cnt_q >= div_q)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      lead_q      <= 1'b1;
      cs_n_q      <= 1'b1;
      pushed_q    <= 1'b0;
      miso_sync_q <= '0;
      samp_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sh_q     <= tx_sh_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      lead_q      <= lead_d;
      cs_n_q      <= (state_d == S_IDLE);
      pushed_q    <= (state_q == S_DONE) && (pushed_q || rx_push);
      miso_sync_q <= {miso_sync_q[0], miso};
      // Sample strobe is delayed to line up with the synchronised miso of that edge.
      samp_pipe_q <= {samp_pipe_q[0], sample_fire};
      if (samp_pipe_q[1]) rx_sh_q <= {rx_sh_q[W_DATA-2:0], miso_sync_q[1]};
    end
  end

  always_comb begin
    status_word              = '0;
    status_word[ST_TX_EMPTY] = tx_empty;
    status_word[ST_TX_FULL]  = tx_full;
    status_word[ST_RX_EMPTY] = rx_empty;
    status_word[ST_RX_FULL]  = rx_full;
    status_word[ST_BUSY]     = busy;
    status_word[ST_TX_OVF]   = tx_ovf_q;
    status_word[ST_RX_OVF]   = rx_ovf_q;
    status_word[ST_RX_UDF]   = rx_udf_q;
  end

  always_comb begin
    ctrl_word                          = '0;
    ctrl_word[CT_EN]                   = en_q;
    ctrl_word[CT_CPOL]                 = cpol_q;
    ctrl_word[CT_CPHA]                 = cpha_q;
    ctrl_word[CT_IE_TX]                = ie_tx_q;
    ctrl_word[CT_IE_RX]                = ie_rx_q;
    ctrl_word[CT_DIV_LSB +: W_DIV]     = div_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      en_q     <= 1'b0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      ie_tx_q  <= 1'b0;
      ie_rx_q  <= 1'b0;
      div_q    <= '0;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
    end else begin
      if (rd_en) begin
        case (addr)
          A_DATA:   rdata_q <= rx_empty ? '0 : rx_head;
          A_STATUS: rdata_q <= status_word;
          A_CTRL:   rdata_q <= ctrl_word;
          default:  rdata_q <= '0;
        endcase
      end
      if (wr_ctrl) begin
        en_q    <= wdata[CT_EN];
        ie_tx_q <= wdata[CT_IE_TX];
        ie_rx_q <= wdata[CT_IE_RX];
        if (!busy) begin
          cpol_q <= wdata[CT_CPOL];
          cpha_q <= wdata[CT_CPHA];
          div_q  <= wdata[CT_DIV_LSB +: W_DIV];
        end
      end
      // A new error in the same cycle as a clear keeps the flag set.
      tx_ovf_q <= (wr_data && tx_full && !tx_pop)
                | (tx_ovf_q && !(wr_status && wdata[ST_TX_OVF]));
      rx_ovf_q <= (rx_push && rx_full && !rx_pop)
                | (rx_ovf_q && !(wr_status && wdata[ST_RX_OVF]));
      rx_udf_q <= (rd_data && rx_empty)
                | (rx_udf_q && !(wr_status && wdata[ST_RX_UDF]));
    end
  end

  assign rdata = rdata_q;
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;
  assign cs_n  = cs_n_q;
  assign irq   = (!rx_empty && ie_rx_q) || (tx_empty && ie_tx_q);

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: register map, loopback and slave-model transfers
// in all SPI modes, FIFO overflow/underflow, back-to-back bursts and async reset.
module tb_spi_master_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq, sclk, mosi, cs_n, miso;

  int checks = 0;
  int errors = 0;

  logic        loopback = 1'b1;
  logic        mode_cpol = 1'b0;
  logic        mode_cpha = 1'b0;
  logic [31:0] slv_tx = '0;
  logic [31:0] slv_sh = '0;
  logic [31:0] slv_rx = '0;
  logic        slv_miso = 1'b0;
  logic        slv_cs_sclk = 1'b0;
  logic        sclk_prev = 1'b0;
  logic        cs_prev = 1'b1;
  int          slv_bits = 0;
  int          sclk_rises = 0;
  int          cs_rises = 0;
  time         t_last = 0;
  time         t_prev = 0;

  always #5 clk = ~clk;

  assign miso = loopback ? mosi : slv_miso;

  spi_master_fifo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq),
    .sclk  (sclk),
    .mosi  (mosi),
    .miso  (miso),
    .cs_n  (cs_n)
  );

  always @(posedge sclk) begin
    if (!cs_n) begin
      sclk_rises++;
      t_prev = t_last;
      t_last = $time;
    end
  end

  always @(posedge cs_n) cs_rises++;

  // Slave: sample mosi on the sampling edge of the mode, shift its own word out on the other.
  always @(sclk or cs_n) begin
    if (cs_prev && !cs_n) begin
      slv_sh      = slv_tx;
      slv_rx      = '0;
      slv_bits    = 0;
      slv_cs_sclk = sclk;
      if (!mode_cpha) slv_miso = slv_tx[31];
    end else if (!cs_n && (sclk !== sclk_prev)) begin
      if ((sclk != mode_cpol) == !mode_cpha) begin
        slv_rx = {slv_rx[30:0], mosi};
        slv_bits++;
      end else if (!mode_cpha) begin
        slv_sh   = slv_sh << 1;
        slv_miso = slv_sh[31];
      end else begin
        slv_miso = slv_sh[31];
        slv_sh   = slv_sh << 1;
      end
    end
    sclk_prev = sclk;
    cs_prev   = cs_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    addr  = a;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    d     = rdata;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] st;
    bit          done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      cpu_read(2'd1, st);
      if (st[0] && !st[4]) done = 1'b1;
    end
    check(tag, {31'b0, done}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [31:0] ctrl;
    logic [31:0] word;
    int          base;
    int          cbase;

    repeat (3) @(negedge clk);
    check("rst_cs_n",  {31'b0, cs_n}, 32'd1);
    check("rst_sclk",  {31'b0, sclk}, 32'd0);
    check("rst_mosi",  {31'b0, mosi}, 32'd0);
    check("rst_irq",   {31'b0, irq},  32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;

    // Async reset in the middle of a word
    cpu_write(2'd2, 32'h0000_0001);
    base = sclk_rises;
    cpu_write(2'd0, 32'hA5A5_A5A5);
    for (int i = 0; i < 200 && (sclk_rises - base) < 4; i++) @(negedge clk);
    check("t1_shifting", {31'b0, (sclk_rises - base) >= 4}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_cs_n_async", {31'b0, cs_n}, 32'd1);
    check("t1_sclk_async", {31'b0, sclk}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    cpu_read(2'd1, d);
    check("t1_status", d, 32'h05);
    cpu_read(2'd2, d);
    check("t1_ctrl", d, 32'h00);

    // Loopback, mode 0, div 0, rx interrupt enabled
    cpu_write(2'd2, 32'h0000_0011);
    base = sclk_rises;
    cpu_write(2'd0, 32'h1234_5678);
    wait_idle("t2_idle");
    check("t2_sclk_rises", sclk_rises - base, 32'd32);
    check("t2_sclk_period", 32'(t_last - t_prev), 32'd20);
    check("t2_irq_set", {31'b0, irq}, 32'd1);
    cpu_read(2'd1, d);
    check("t2_status_pre", d, 32'h01);
    cpu_read(2'd0, d);
    check("t2_data", d, 32'h1234_5678);
    check("t2_irq_clr", {31'b0, irq}, 32'd0);
    cpu_read(2'd1, d);
    check("t2_status_post", d, 32'h05);

    // Modes 1..3 against the slave model, div 3
    loopback = 1'b0;
    slv_tx   = 32'hDEAD_BEEF;
    for (int m = 1; m <= 3; m++) begin
      mode_cpol = m[1];
      mode_cpha = m[0];
      ctrl = 32'h0000_0300 | {29'b0, mode_cpha, mode_cpol, 1'b0};
      word = 32'hC3A5_0F00 | m;
      cpu_write(2'd2, ctrl);
      repeat (2) @(negedge clk);
      check($sformatf("t3_m%0d_idle_sclk", m), {31'b0, sclk}, {31'b0, mode_cpol});
      cpu_read(2'd2, d);
      check($sformatf("t3_m%0d_ctrl", m), d, ctrl);
      cpu_write(2'd0, word);
      base = sclk_rises;
      cpu_write(2'd2, ctrl | 32'h1);
      wait_idle($sformatf("t3_m%0d_idle", m));
      check($sformatf("t3_m%0d_slave_rx", m), slv_rx, word);
      check($sformatf("t3_m%0d_slave_bits", m), slv_bits, 32'd32);
      check($sformatf("t3_m%0d_cs_sclk", m), {31'b0, slv_cs_sclk}, {31'b0, mode_cpol});
      check($sformatf("t3_m%0d_rises", m), sclk_rises - base, 32'd32);
      check($sformatf("t3_m%0d_period", m), 32'(t_last - t_prev), 32'd80);
      check($sformatf("t3_m%0d_end_sclk", m), {31'b0, sclk}, {31'b0, mode_cpol});
      cpu_read(2'd0, d);
      check($sformatf("t3_m%0d_data", m), d, 32'hDEAD_BEEF);
    end

    // TX overflow with the engine disabled
    loopback  = 1'b1;
    mode_cpol = 1'b0;
    mode_cpha = 1'b0;
    cpu_write(2'd2, 32'h0);
    for (int i = 1; i <= 5; i++) cpu_write(2'd0, 32'h1111_1111 * i);
    cpu_read(2'd1, d);
    check("t4_status_ovf", d, 32'h26);
    cpu_write(2'd1, 32'h20);
    cpu_read(2'd1, d);
    check("t4_status_clr", d, 32'h06);
    cpu_write(2'd2, 32'h1);
    wait_idle("t4_idle");
    cpu_read(2'd1, d);
    check("t4_status_rx_full", d, 32'h09);
    for (int i = 1; i <= 4; i++) begin
      cpu_read(2'd0, d);
      check($sformatf("t4_rx%0d", i), d, 32'h1111_1111 * i);
    end
    cpu_read(2'd1, d);
    check("t4_status_end", d, 32'h05);

    // Back-to-back burst of three words
    cpu_write(2'd2, 32'h0);
    for (int i = 1; i <= 3; i++) cpu_write(2'd0, 32'hA000_0000 + i);
    base  = sclk_rises;
    cbase = cs_rises;
    cpu_write(2'd2, 32'h1);
    repeat (4) @(negedge clk);
    cpu_read(2'd1, d);
    check("t5_busy", {31'b0, d[4]}, 32'd1);
    wait_idle("t5_idle");
    check("t5_cs_rises", cs_rises - cbase, 32'd1);
    check("t5_sclk_rises", sclk_rises - base, 32'd96);
    cpu_read(2'd1, d);
    check("t5_status", d, 32'h01);
    for (int i = 1; i <= 3; i++) begin
      cpu_read(2'd0, d);
      check($sformatf("t5_rx%0d", i), d, 32'hA000_0000 + i);
    end

    // RX overflow, then underflow
    for (int i = 1; i <= 5; i++) cpu_write(2'd0, 32'hC0DE_0000 + i);
    wait_idle("t6_idle");
    cpu_read(2'd1, d);
    check("t6_status_ovf", d, 32'h49);
    for (int i = 1; i <= 4; i++) begin
      cpu_read(2'd0, d);
      check($sformatf("t6_rx%0d", i), d, 32'hC0DE_0000 + i);
    end
    cpu_read(2'd0, d);
    check("t6_udf_data", d, 32'h0);
    cpu_read(2'd1, d);
    check("t6_status_udf", d, 32'hC5);
    cpu_write(2'd1, 32'hE0);
    cpu_read(2'd1, d);
    check("t6_status_clr", d, 32'h05);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
